// File: rtl/sys1_vid_pkg.sv
// Shared System 1 video definitions: tile fetch states, map geometry and
// VRAM word field positions used by the tilemap layer generators.
package sys1_vid_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VADDR,
        ST_VWAIT,
        ST_TREQ,
        ST_FULL
    } fetch_st_e;

    localparam int TILE_W        = 8;
    localparam int MAP_COLS      = 32;
    localparam int VRAM_CODE_MSB = 15;
    localparam int VRAM_PAL_LSB  = 5;
endpackage

// File: rtl/sys1_bg_layer_if.sv
// Tile-ROM fetch port between a layer generator (master) and the shared
// tile-ROM arbiter (slave); tile_dt is valid in the cycle tile_ack is high.
interface sys1_bg_layer_if #(
    parameter int PLANES = 3,
    parameter int CODEW  = 12
);
    logic                  tile_req;
    logic [CODEW+2:0]      tile_ad;
    logic                  tile_ack;
    logic [8*PLANES-1:0]   tile_dt;

    modport master (output tile_req, tile_ad, input tile_ack, tile_dt);
    modport slave  (input tile_req, tile_ad, output tile_ack, tile_dt);
endinterface

// File: rtl/sys1_tile_shifter.sv
// Per-layer pixel shifter: plane bytes shift out MSB first, palette is held
// for the whole tile, output is registered and forced transparent when off.
module sys1_tile_shifter
    import sys1_vid_pkg::*;
#(
    parameter int PLANES = 3,
    parameter int PALW   = 8
) (
    input  logic                        VCLK,
    input  logic                        RESET,
    input  logic                        enable,
    input  logic                        load,
    input  logic                        pal_en,
    input  logic [PLANES-1:0][7:0]      ld_dt,
    input  logic [PALW-1:0]             ld_pal,
    output logic [PALW+PLANES-1:0]      opix
);
    logic [PLANES-1:0][7:0]   sh_q, sh_d;
    logic [PALW-1:0]          pal_q, pal_d;
    logic [PALW+PLANES-1:0]   opix_q, opix_d;
    logic [PLANES-1:0]        col;

    always_comb begin
        col = '0;
        // plane0 drives the colour MSB
        for (int k = 0; k < PLANES; k++) col[k] = sh_q[PLANES-1-k][7];
        sh_d = ld_dt;
        if (!load)
            for (int p = 0; p < PLANES; p++) sh_d[p] = {sh_q[p][6:0], 1'b0};
        pal_d  = (load && pal_en) ? ld_pal : pal_q;
        opix_d = enable ? {pal_q, col} : '0;
    end

    always_ff @(posedge VCLK or posedge RESET) begin
        if (RESET) begin
            sh_q   <= '0;
            pal_q  <= '0;
            opix_q <= '0;
        end else begin
            sh_q   <= sh_d;
            pal_q  <= pal_d;
            opix_q <= opix_d;
        end
    end

    assign opix = opix_q;
endmodule

// File: rtl/sys1_bg_layer.sv
// Tilemap layer generator: latches scroll in hblank, fetches the next tile
// through VRAM and the tile-ROM handshake into a one-tile prefetch buffer.
module sys1_bg_layer
    import sys1_vid_pkg::*;
#(
    parameter int         PLANES  = 3,
    parameter int         PALW    = 8,
    parameter int         CODEW   = 12,
    parameter logic [8:0] LATCH_H = 9'h1F0
) (
    input  logic                     VCLK,
    input  logic                     RESET,
    input  logic [8:0]               HP,
    input  logic [8:0]               VP,
    input  logic [8:0]               scrx,
    input  logic [7:0]               scry,
    input  logic                     enable,
    output logic [9:0]               vram_ad,
    input  logic [15:0]              vram_dt,
    sys1_bg_layer_if.master          tbus,
    output logic [PALW+PLANES-1:0]   opix,
    output logic                     underrun,
    input  logic                     underrun_clr
);
    localparam int COLW = $clog2(MAP_COLS);
    localparam int PXW  = $clog2(TILE_W);
    localparam logic [PXW-1:0] LAST_PX = PXW'(TILE_W - 1);

    fetch_st_e             st_q, st_d;
    logic [8:0]            sx_q, sx_d;
    logic [7:0]            sy_q, sy_d;
    logic [9:0]            vram_ad_q, vram_ad_d;
    logic [CODEW+2:0]      tile_ad_q, tile_ad_d;
    logic                  tile_req_q, tile_req_d;
    logic [PALW-1:0]       cpal_q, cpal_d;
    logic                  pf_vld_q, pf_vld_d;
    logic [8*PLANES-1:0]   pf_dt_q, pf_dt_d;
    logic [PALW-1:0]       pf_pal_q, pf_pal_d;
    logic                  late_q, late_d;
    logic                  underrun_q, underrun_d;

    logic [8:0]            bx;
    logic [7:0]            by;
    logic [COLW-1:0]       ncol;
    logic                  start, load_pt, ack, urun_set;
    logic [CODEW-1:0]      code_w;
    logic [PALW-1:0]       pal_w;
    logic                  sh_load, sh_pal_en;
    logic [8*PLANES-1:0]   sh_dt;
    logic [PALW-1:0]       sh_pal;
    logic                  unused_bits;

    assign bx      = HP + sx_q;
    assign by      = VP[7:0] + sy_q;
    assign ncol    = bx[PXW+COLW-1:PXW] + COLW'(1);
    assign start   = (bx[PXW-1:0] == '0);
    assign load_pt = (bx[PXW-1:0] == LAST_PX);
    assign code_w  = {vram_dt[VRAM_CODE_MSB], vram_dt[CODEW-2:0]};
    assign pal_w   = vram_dt[VRAM_PAL_LSB +: PALW];
    // acks outside TREQ belong to nobody (e.g. a grant racing a reset)
    assign ack     = tbus.tile_ack && (st_q == ST_TREQ);
    assign unused_bits = ^{bx[8], VP[8], vram_dt};

    always_comb begin
        sx_d       = (HP == LATCH_H) ? scrx : sx_q;
        sy_d       = (HP == LATCH_H) ? scry : sy_q;
        st_d       = st_q;
        vram_ad_d  = vram_ad_q;
        tile_ad_d  = tile_ad_q;
        tile_req_d = tile_req_q;
        cpal_d     = cpal_q;
        pf_vld_d   = pf_vld_q;
        pf_dt_d    = pf_dt_q;
        pf_pal_d   = pf_pal_q;
        late_d     = late_q;
        urun_set   = 1'b0;
        sh_load    = 1'b0;
        sh_pal_en  = 1'b0;
        sh_dt      = '0;
        sh_pal     = pf_pal_q;

        case (st_q)
            ST_IDLE: if (start) begin
                st_d      = ST_VADDR;
                vram_ad_d = {by[7:PXW], ncol};
            end
            ST_VADDR: st_d = ST_VWAIT;
            ST_VWAIT: begin
                st_d       = ST_TREQ;
                cpal_d     = pal_w;
                tile_ad_d  = {code_w, by[PXW-1:0]};
                tile_req_d = 1'b1;
            end
            ST_TREQ: if (ack) begin
                tile_req_d = 1'b0;
                if (late_q) begin
                    // stale tile: drop it, but don't lose a fetch slot starting now
                    late_d = 1'b0;
                    if (start) begin
                        st_d      = ST_VADDR;
                        vram_ad_d = {by[7:PXW], ncol};
                    end else begin
                        st_d = ST_IDLE;
                    end
                end else if (load_pt) begin
                    st_d = ST_IDLE;
                end else begin
                    pf_vld_d = 1'b1;
                    pf_dt_d  = tbus.tile_dt;
                    pf_pal_d = cpal_q;
                    st_d     = ST_FULL;
                end
            end
            ST_FULL: if (load_pt) st_d = ST_IDLE;
            default: st_d = ST_IDLE;
        endcase

        if (load_pt) begin
            sh_load = 1'b1;
            if (pf_vld_q) begin
                sh_dt     = pf_dt_q;
                sh_pal    = pf_pal_q;
                sh_pal_en = 1'b1;
                pf_vld_d  = 1'b0;
            end else if (ack && !late_q) begin
                sh_dt     = tbus.tile_dt;
                sh_pal    = cpal_q;
                sh_pal_en = 1'b1;
            end else begin
                urun_set = 1'b1;
                if ((st_q inside {ST_VADDR, ST_VWAIT, ST_TREQ}) && !ack) late_d = 1'b1;
            end
        end

        underrun_d = underrun_clr ? 1'b0 : (urun_set ? 1'b1 : underrun_q);
    end

    always_ff @(posedge VCLK or posedge RESET) begin
        if (RESET) begin
            st_q       <= ST_IDLE;
            sx_q       <= '0;
            sy_q       <= '0;
            vram_ad_q  <= '0;
            tile_ad_q  <= '0;
            tile_req_q <= 1'b0;
            cpal_q     <= '0;
            pf_vld_q   <= 1'b0;
            pf_dt_q    <= '0;
            pf_pal_q   <= '0;
            late_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            st_q       <= st_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            vram_ad_q  <= vram_ad_d;
            tile_ad_q  <= tile_ad_d;
            tile_req_q <= tile_req_d;
            cpal_q     <= cpal_d;
            pf_vld_q   <= pf_vld_d;
            pf_dt_q    <= pf_dt_d;
            pf_pal_q   <= pf_pal_d;
            late_q     <= late_d;
            underrun_q <= underrun_d;
        end
    end

    sys1_tile_shifter #(.PLANES(PLANES), .PALW(PALW)) u_shifter (
        .VCLK   (VCLK),
        .RESET  (RESET),
        .enable (enable),
        .load   (sh_load),
        .pal_en (sh_pal_en),
        .ld_dt  (sh_dt),
        .ld_pal (sh_pal),
        .opix   (opix)
    );

    assign vram_ad       = vram_ad_q;
    assign tbus.tile_req = tile_req_q;
    assign tbus.tile_ad  = tile_ad_q;
    assign underrun      = underrun_q;
endmodule

// File: tb/tb_sys1_bg_layer.sv
// Directed bench for sys1_bg_layer: VRAM/tile-ROM models with a programmable
// ack delay; expected pixels are hand-computed per scenario.
module tb_sys1_bg_layer;
    logic        VCLK;
    logic        RESET;
    logic [8:0]  HP, VP, scrx;
    logic [7:0]  scry;
    logic        enable, underrun_clr, underrun;
    logic [9:0]  vram_ad;
    logic [15:0] vram_dt;
    logic [10:0] opix;

    logic [15:0] vram [0:1023];
    int          ack_dly;
    logic        ack_force;
    int          req_cnt;
    logic [8:0]  last_hp;
    int          n_chk, n_pass;

    sys1_bg_layer_if #(.PLANES(3), .CODEW(12)) tbus ();

    sys1_bg_layer #(.PLANES(3), .PALW(8), .CODEW(12), .LATCH_H(9'h1F0)) dut (
        .VCLK         (VCLK),
        .RESET        (RESET),
        .HP           (HP),
        .VP           (VP),
        .scrx         (scrx),
        .scry         (scry),
        .enable       (enable),
        .vram_ad      (vram_ad),
        .vram_dt      (vram_dt),
        .tbus         (tbus),
        .opix         (opix),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    initial VCLK = 1'b0;
    always #5 VCLK = ~VCLK;

    function automatic logic [23:0] rom(input logic [14:0] ad);
        case (ad[14:3])
            12'h025: rom = 24'h000080;
            12'h045: rom = 24'h008000;
            12'h0C3: rom = (ad[2:0] == 3'd4) ? 24'h0F00FF : 24'h000000;
            default: rom = 24'h000000;
        endcase
    endfunction

    // memory and arbiter models update mid-cycle, stable across the next edge
    always @(negedge VCLK) begin
        vram_dt = vram[vram_ad];
        if (tbus.tile_req) req_cnt = req_cnt + 1;
        else               req_cnt = 0;
        tbus.tile_ack = (tbus.tile_req && req_cnt == ack_dly + 1) || ack_force;
        tbus.tile_dt  = rom(tbus.tile_ad);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %h, expected %h", tag, act, exp);
    endtask

    task automatic cyc();
        @(posedge VCLK);
        #1;
        last_hp = HP;
        HP = HP + 9'd1;
    endtask

    // run until the edge presenting HP==h has been taken
    task automatic upto(input logic [8:0] h);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (last_hp != h && n < 1100);
        if (last_hp != h) chk("upto_timeout", {23'b0, last_hp}, {23'b0, h});
    endtask

    task automatic restart(input logic [8:0] sx, input logic [7:0] sy, input int d);
        RESET = 1'b1;
        ack_dly = d;
        ack_force = 1'b0;
        enable = 1'b1;
        underrun_clr = 1'b0;
        scrx = sx;
        scry = sy;
        VP = 9'd0;
        HP = 9'h1F0;
        @(negedge VCLK);
        RESET = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; req_cnt = 0;
        RESET = 1'b1; HP = '0; VP = '0; scrx = '0; scry = '0;
        enable = 1'b1; underrun_clr = 1'b0; ack_force = 1'b0; ack_dly = 99;
        for (int i = 0; i < 1024; i++) vram[i] = 16'h0000;
        vram[0] = 16'h00C3;
        vram[1] = 16'h0025;
        vram[2] = 16'h0045;
        #22;

        // reset while a request is outstanding
        restart(9'd0, 8'd0, 99);
        upto(9'h1F2);
        chk("req_up", tbus.tile_req, 1);
        #2 RESET = 1'b1;
        #1;
        chk("rst_req", tbus.tile_req, 0);
        chk("rst_opix", opix, 0);
        chk("rst_urun", underrun, 0);
        chk("rst_vram_ad", vram_ad, 0);
        chk("rst_tile_ad", tbus.tile_ad, 0);
        RESET = 1'b0;
        cyc(); cyc();
        ack_force = 1'b1;
        cyc();
        ack_force = 1'b0;
        chk("stray_ack_req", tbus.tile_req, 0);
        chk("stray_ack_urun", underrun, 0);

        // basic tile, no scroll, ack one cycle after req
        restart(9'd0, 8'd0, 1);
        upto(9'd8);
        chk("t2_px0", opix, 11'h00C);
        for (int p = 1; p < 8; p++) begin
            cyc();
            chk("t2_pxN", opix, 11'h008);
        end
        chk("t2_urun", underrun, 0);

        // scroll wrap: BX 511->0, ncol 31->0, row 4 of tile 0x0C3
        restart(9'h1FD, 8'h04, 1);
        upto(9'h1FB);
        chk("t3_vram_ad", vram_ad, 10'h000);
        upto(9'h1FD);
        chk("t3_tile_ad", tbus.tile_ad, 15'h061C);
        upto(9'd3);
        chk("t3_px0", opix, 11'h034);
        upto(9'd7);
        chk("t3_px4", opix, 11'h035);
        upto(9'd10);
        chk("t3_px7", opix, 11'h035);

        // late ack -> underrun, clear, next tile still correct
        restart(9'd0, 8'd0, 1);
        upto(9'h1FF);
        ack_dly = 5;
        upto(9'd7);
        chk("t4_urun_set", underrun, 1);
        upto(9'd8);
        chk("t4_px0_col", opix[2:0], 0);
        ack_dly = 1;
        underrun_clr = 1'b1;
        cyc();
        underrun_clr = 1'b0;
        chk("t4_urun_clr", underrun, 0);
        chk("t4_px1_col", opix[2:0], 0);
        upto(9'd16);
        chk("t4_next_px0", opix, 11'h012);
        cyc();
        chk("t4_next_px1", opix, 11'h010);
        chk("t4_urun_stay", underrun, 0);

        // ack lands exactly on the load edge -> bypass
        restart(9'd0, 8'd0, 4);
        upto(9'd7);
        chk("t5_req_drop", tbus.tile_req, 0);
        cyc();
        chk("t5_px0", opix, 11'h00C);
        cyc();
        chk("t5_px1", opix, 11'h008);
        chk("t5_urun", underrun, 0);

        // mid-line scroll change waits for the latch point; enable gating
        restart(9'd0, 8'd0, 1);
        upto(9'd4);
        scrx = 9'd4;
        upto(9'd8);
        chk("t6_noshift_px0", opix, 11'h00C);
        cyc();
        chk("t6_noshift_px1", opix, 11'h008);
        enable = 1'b0;
        cyc();
        chk("t6_dis_opix", opix, 0);
        upto(9'd18);
        chk("t6_dis_req", tbus.tile_req, 1);
        chk("t6_dis_opix2", opix, 0);
        enable = 1'b1;
        upto(9'h1F0);
        upto(9'd4);
        chk("t6_shift_px0", opix, 11'h00C);
        cyc();
        chk("t6_shift_px1", opix, 11'h008);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
